// File: rtl/cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run/step sequencer for the 5-stage pipelined cpu. It generates the
// pipeline-wide enable, detects a HALT word at fetch and drains the pipeline,
// and it owns the external program/data load ports, which are granted only
// while the core is idle.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   arst_n       synchronous active-low reset
//   start        pulse: clear cycle_count and free-run
//   step         pulse: execute exactly one enabled cycle
//   stop         request an orderly stop (drain) while running
//   max_cycles   RUN cycle budget, 0 = unlimited
//   instruction  word currently fetched from instruction memory
//   im_*_req     external instruction-memory write/read requests
//   dm_*_req     external data-memory write/read requests
//   im_*_ext     instruction-memory requests gated by ext_grant
//   dm_*_ext     data-memory requests gated by ext_grant
//   cpu_enable   enable to the PC and all pipeline registers
//   pc_hold      freezes the PC while the pipe keeps moving (drain)
//   if_nop       replace the IF/ID instruction with 32'h0
//   ext_grant    external memory access allowed (IDLE only)
//   busy         sequencer is not idle
//   done         one-cycle pulse when the drain finishes
//   halted       sticky: last run ended on HALT_WORD
//   state        IDLE=0 RUN=1 STEP=2 DRAIN=3
//   cycle_count  enabled cycles since last start, saturating
// ----------------------------------------------------------------------------
module cpu_run_ctrl #(
   parameter int          CNT_W        = 32,
   parameter int          DRAIN_CYCLES = 4,
   parameter logic [31:0] HALT_WORD    = 32'hFC00_0000
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             start,
   input  logic             step,
   input  logic             stop,
   input  logic [CNT_W-1:0] max_cycles,
   input  logic [31:0]      instruction,
   input  logic             im_wen_req,
   input  logic             im_ren_req,
   input  logic             dm_wen_req,
   input  logic             dm_ren_req,
   output logic             im_wen_ext,
   output logic             im_ren_ext,
   output logic             dm_wen_ext,
   output logic             dm_ren_ext,
   output logic             cpu_enable,
   output logic             pc_hold,
   output logic             if_nop,
   output logic             ext_grant,
   output logic             busy,
   output logic             done,
   output logic             halted,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_STEP  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic             halted_d;
   logic             done_d;
   logic             halt_fetch;
   logic             budget_hit;
   logic [CNT_W-1:0] count_inc;

   assign halt_fetch = (instruction == HALT_WORD);
   assign count_inc  = cycle_count + CNT_ONE;
   // A saturated counter wraps count_inc to 0, which never equals a non-zero
   // budget, so the saturated case cannot trigger a spurious stop.
   assign budget_hit = (max_cycles != '0) && (count_inc == max_cycles);

   // -------------------------------------------------------------------------
   // State register and registered outputs
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, regardless of statement order.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q     <= S_IDLE;
         drain_q     <= '0;
         halted      <= 1'b0;
         done        <= 1'b0;
         cycle_count <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         halted  <= halted_d;
         done    <= done_d;
         // start only acts from IDLE, where the pipe is disabled, so the
         // clear and the increment can never collide.
         if (state_q == S_IDLE && start)
            cycle_count <= '0;
         else if (cpu_enable && cycle_count != CNT_MAX)
            cycle_count <= count_inc;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave it unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      drain_d  = drain_q;
      halted_d = halted;
      done_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // start wins over a simultaneous step; stop is meaningless here.
            if (start) begin
               state_d  = S_RUN;
               halted_d = 1'b0;
            end else if (step) begin
               state_d  = S_STEP;
               halted_d = 1'b0;
            end
         end
         S_RUN: begin
            if (halt_fetch || stop || budget_hit) begin
               state_d  = S_DRAIN;
               drain_d  = DRAIN_LOAD;
               halted_d = halt_fetch;
            end
         end
         S_STEP: begin
            if (halt_fetch) begin
               state_d  = S_DRAIN;
               drain_d  = DRAIN_LOAD;
               halted_d = 1'b1;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (drain_q == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Output decode
   // -------------------------------------------------------------------------
   always_comb begin
      cpu_enable = (state_q != S_IDLE);
      pc_hold    = (state_q == S_DRAIN);
      ext_grant  = (state_q == S_IDLE);
      busy       = (state_q != S_IDLE);
      // The HALT word is replaced by a NOP on the cycle it is fetched, and
      // during the drain the frozen PC keeps presenting it, so it is
      // suppressed there too; nothing after it ever enters IF/ID.
      if_nop     = (state_q == S_DRAIN) ||
                   (((state_q == S_RUN) || (state_q == S_STEP)) && halt_fetch);
      im_wen_ext = im_wen_req & ext_grant;
      im_ren_ext = im_ren_req & ext_grant;
      dm_wen_ext = dm_wen_req & ext_grant;
      dm_ren_ext = dm_ren_req & ext_grant;
   end

   assign state = state_q;

endmodule
